// File: rtl/alu_unit.sv
// alu_unit: single-issue RV32I integer ALU with a registered one-cycle result broadcast.
// Define ALU_MUL_EN to add the two-cycle RV32M MUL/MULH/MULHSU/MULHU path (IDLE/MUL FSM).
module alu_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback,
    input  logic        alu_en,
    input  logic [6:0]  alu_opcode,
    input  logic [2:0]  alu_func3,
    input  logic        alu_func1,
    input  logic        alu_func_m,
    input  logic [31:0] alu_val1,
    input  logic [31:0] alu_val2,
    input  logic [31:0] alu_imm,
    input  logic [31:0] alu_pc,
    input  logic [3:0]  alu_rob_pos,
    output logic        alu_busy,
    output logic        result,
    output logic [3:0]  result_rob_pos,
    output logic [31:0] result_val,
    output logic        result_jump,
    output logic [31:0] result_pc
);

    localparam int DATA_W = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic              jump;
        logic [DATA_W-1:0] val;
        logic [DATA_W-1:0] npc;
    } alu_out_t;

    function automatic logic [DATA_W-1:0] int_op(
        input logic [2:0]        f3,
        input logic              alt,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic signed [DATA_W-1:0] sa;
        logic signed [DATA_W-1:0] sb;
        logic [4:0]               sh;
        logic [DATA_W-1:0]        r;
        sa = a;
        sb = b;
        sh = b[4:0];
        r  = '0;
        case (f3)
            3'b000: r = alt ? (a - b) : (a + b);
            3'b001: r = a << sh;
            3'b010: r = {{(DATA_W-1){1'b0}}, (sa < sb)};
            3'b011: r = {{(DATA_W-1){1'b0}}, (a < b)};
            3'b100: r = a ^ b;
            3'b101: begin
                if (alt) r = sa >>> sh;
                else     r = a >> sh;
            end
            3'b110: r = a | b;
            3'b111: r = a & b;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Returns taken in bit 0 and "func3 is a defined branch" in bit 1.
    function automatic logic [1:0] branch_eval(
        input logic [2:0]        f3,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic signed [DATA_W-1:0] sa;
        logic signed [DATA_W-1:0] sb;
        logic [1:0]               r;
        sa = a;
        sb = b;
        r  = 2'b00;
        case (f3)
            3'b000: r = {1'b1, (a == b)};
            3'b001: r = {1'b1, (a != b)};
            3'b100: r = {1'b1, (sa < sb)};
            3'b101: r = {1'b1, (sa >= sb)};
            3'b110: r = {1'b1, (a < b)};
            3'b111: r = {1'b1, (a >= b)};
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    function automatic alu_out_t exec_base(
        input logic [6:0]        opcode,
        input logic [2:0]        f3,
        input logic              f1,
        input logic [DATA_W-1:0] v1,
        input logic [DATA_W-1:0] v2,
        input logic [DATA_W-1:0] imm,
        input logic [DATA_W-1:0] pc
    );
        alu_out_t          o;
        logic [1:0]        br;
        logic [DATA_W-1:0] pc4;
        o   = '0;
        br  = branch_eval(f3, v1, v2);
        pc4 = pc + 32'd4;
        case (opcode)
            OPC_OP:    o.val = int_op(f3, f1, v1, v2);
            OPC_OPIMM: o.val = int_op(f3, f1 && (f3 == 3'b101), v1, imm);
            OPC_LUI:   o.val = imm;
            OPC_AUIPC: o.val = pc + imm;
            OPC_JAL: begin
                o.val  = pc4;
                o.jump = 1'b1;
                o.npc  = pc + imm;
            end
            OPC_JALR: begin
                o.val  = pc4;
                o.jump = 1'b1;
                o.npc  = (v1 + imm) & 32'hFFFF_FFFE;
            end
            OPC_BRANCH: begin
                if (br[1]) begin
                    o.val  = {{(DATA_W-1){1'b0}}, br[0]};
                    o.jump = br[0];
                    o.npc  = br[0] ? (pc + imm) : pc4;
                end
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    logic     in_idle;
    logic     is_mul_p0;
    logic     mext_nop_p0;
    logic     mul_done;
    logic     issue_p0;
    alu_out_t ex_p0;
    logic [DATA_W-1:0] done_val;
    logic [3:0]        done_rob;

`ifdef ALU_MUL_EN
    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] mul_val_p1;
    logic [3:0]        mul_rob_p1;

    // f3: 00 MUL (low word), 01 MULH, 10 MULHSU, 11 MULHU.
    function automatic logic [DATA_W-1:0] mul_op(
        input logic [1:0]        f3,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic signed [2*DATA_W:0] ea;
        logic signed [2*DATA_W:0] eb;
        logic signed [2*DATA_W:0] prod;
        ea   = {{(DATA_W+1){a[DATA_W-1] & (f3 != 2'b11)}}, a};
        eb   = {{(DATA_W+1){b[DATA_W-1] & (f3 == 2'b01)}}, b};
        prod = ea * eb;
        return (f3 == 2'b00) ? prod[DATA_W-1:0] : prod[2*DATA_W-1:DATA_W];
    endfunction

    assign in_idle     = (state == S_IDLE);
    assign mul_done    = (state == S_MUL);
    assign is_mul_p0   = (alu_opcode == OPC_OP) && alu_func_m && !alu_func3[2];
    assign mext_nop_p0 = (alu_opcode == OPC_OP) && alu_func_m && alu_func3[2];
    assign alu_busy    = mul_done;
    assign done_val    = mul_val_p1;
    assign done_rob    = mul_rob_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (rollback) begin
            state_next = S_IDLE;
        end else if (rdy) begin
            case (state)
                S_IDLE:  if (alu_en && is_mul_p0) state_next = S_MUL;
                S_MUL:   state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // p0 -> p1: product computed at accept, broadcast one cycle later from MUL.
    always_ff @(posedge clk) begin
        if (rdy && !rollback && in_idle && alu_en && is_mul_p0) begin
            mul_val_p1 <= mul_op(alu_func3[1:0], alu_val1, alu_val2);
            mul_rob_p1 <= alu_rob_pos;
        end
    end
`else
    logic unused_func_m;

    assign unused_func_m = alu_func_m;
    assign in_idle       = 1'b1;
    assign mul_done      = 1'b0;
    assign is_mul_p0     = 1'b0;
    assign mext_nop_p0   = 1'b0;
    assign alu_busy      = 1'b0;
    assign done_val      = '0;
    assign done_rob      = '0;
`endif

    assign issue_p0 = alu_en && in_idle && !is_mul_p0;

    always_comb begin
        ex_p0 = exec_base(alu_opcode, alu_func3, alu_func1, alu_val1, alu_val2, alu_imm, alu_pc);
        if (mext_nop_p0) ex_p0 = '0;
    end

    // p0 -> p1: broadcast register; rollback kills it even while rdy is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result         <= 1'b0;
            result_rob_pos <= '0;
            result_val     <= '0;
            result_jump    <= 1'b0;
            result_pc      <= '0;
        end else if (rollback) begin
            result <= 1'b0;
        end else if (rdy) begin
            if (mul_done) begin
                result         <= 1'b1;
                result_rob_pos <= done_rob;
                result_val     <= done_val;
                result_jump    <= 1'b0;
                result_pc      <= '0;
            end else if (issue_p0) begin
                result         <= 1'b1;
                result_rob_pos <= alu_rob_pos;
                result_val     <= ex_p0.val;
                result_jump    <= ex_p0.jump;
                result_pc      <= ex_p0.npc;
            end else begin
                result <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed literal cases plus randomized traffic checked every cycle
// against a behavioural model of the ALU's issue/result rules.
module tb_alu_unit;

`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    localparam bit [6:0] OP     = 7'h33;
    localparam bit [6:0] OPIMM  = 7'h13;
    localparam bit [6:0] LUI    = 7'h37;
    localparam bit [6:0] AUIPC  = 7'h17;
    localparam bit [6:0] JAL    = 7'h6f;
    localparam bit [6:0] JALR   = 7'h67;
    localparam bit [6:0] BRANCH = 7'h63;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback, alu_en;
    logic [6:0]  alu_opcode;
    logic [2:0]  alu_func3;
    logic        alu_func1, alu_func_m;
    logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
    logic [3:0]  alu_rob_pos;
    logic        alu_busy, result, result_jump;
    logic [3:0]  result_rob_pos;
    logic [31:0] result_val, result_pc;

    int checks = 0;
    int errors = 0;

    alu_unit dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .alu_en(alu_en),
        .alu_opcode(alu_opcode), .alu_func3(alu_func3), .alu_func1(alu_func1),
        .alu_func_m(alu_func_m), .alu_val1(alu_val1), .alu_val2(alu_val2),
        .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rob_pos(alu_rob_pos),
        .alu_busy(alu_busy), .result(result), .result_rob_pos(result_rob_pos),
        .result_val(result_val), .result_jump(result_jump), .result_pc(result_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        mul;
        logic [31:0] val;
        logic        jump;
        logic [31:0] pc;
    } ref_t;

    function automatic bit [31:0] ref_mul(input bit [1:0] f, input bit [31:0] a, input bit [31:0] b);
        longint          sa, sb, ub, p;
        longint unsigned pu;
        sa = int'(a);
        sb = int'(b);
        ub = longint'({32'b0, b});
        case (f)
            2'd0: begin p = sa * sb; return p[31:0]; end
            2'd1: begin p = sa * sb; return p[63:32]; end
            2'd2: begin p = sa * ub; return p[63:32]; end
            default: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
        endcase
    endfunction

    function automatic ref_t ref_exec(input bit [6:0] op, input bit [2:0] f3, input bit f1, input bit fm,
                                      input bit [31:0] a, input bit [31:0] b, input bit [31:0] imm,
                                      input bit [31:0] pc);
        ref_t     r;
        bit [31:0] x;
        bit        take;
        r = '0;
        if (op == OP && fm && MUL_EN) begin
            if (!f3[2]) begin
                r.mul = 1'b1;
                r.val = ref_mul(f3[1:0], a, b);
            end
            return r;
        end
        if (op == OP || op == OPIMM) begin
            x = (op == OP) ? b : imm;
            case (f3)
                3'd0: r.val = (op == OP && f1) ? a - x : a + x;
                3'd1: r.val = a << x[4:0];
                3'd2: r.val = (int'(a) < int'(x)) ? 32'd1 : 32'd0;
                3'd3: r.val = (a < x) ? 32'd1 : 32'd0;
                3'd4: r.val = a ^ x;
                3'd5: r.val = f1 ? 32'(int'(a) >>> x[4:0]) : a >> x[4:0];
                3'd6: r.val = a | x;
                default: r.val = a & x;
            endcase
        end else if (op == LUI) begin
            r.val = imm;
        end else if (op == AUIPC) begin
            r.val = pc + imm;
        end else if (op == JAL) begin
            r.val = pc + 4; r.jump = 1'b1; r.pc = pc + imm;
        end else if (op == JALR) begin
            r.val = pc + 4; r.jump = 1'b1; r.pc = (a + imm) & 32'hFFFF_FFFE;
        end else if (op == BRANCH && f3 != 3'd2 && f3 != 3'd3) begin
            case (f3)
                3'd0: take = (a == b);
                3'd1: take = (a != b);
                3'd4: take = (int'(a) < int'(b));
                3'd5: take = (int'(a) >= int'(b));
                3'd6: take = (a < b);
                default: take = (a >= b);
            endcase
            r.val  = take ? 32'd1 : 32'd0;
            r.jump = take;
            r.pc   = take ? pc + imm : pc + 4;
        end
        return r;
    endfunction

    ref_t        r_now;
    logic        m_result = 1'b0, m_jump = 1'b0, m_busy = 1'b0;
    logic [31:0] m_val = '0, m_pc = '0, m_mval = '0;
    logic [3:0]  m_rob = '0, m_mrob = '0;

    always_comb r_now = ref_exec(alu_opcode, alu_func3, alu_func1, alu_func_m,
                                 alu_val1, alu_val2, alu_imm, alu_pc);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_result <= 1'b0; m_jump <= 1'b0; m_busy <= 1'b0;
            m_val <= '0; m_pc <= '0; m_rob <= '0;
        end else if (rollback) begin
            m_result <= 1'b0; m_busy <= 1'b0;
        end else if (rdy) begin
            if (m_busy) begin
                m_result <= 1'b1; m_val <= m_mval; m_rob <= m_mrob;
                m_jump <= 1'b0; m_pc <= '0; m_busy <= 1'b0;
            end else if (alu_en && r_now.mul) begin
                m_result <= 1'b0; m_busy <= 1'b1; m_mval <= r_now.val; m_mrob <= alu_rob_pos;
            end else if (alu_en) begin
                m_result <= 1'b1; m_val <= r_now.val; m_jump <= r_now.jump;
                m_pc <= r_now.pc; m_rob <= alu_rob_pos;
            end else begin
                m_result <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("result", {31'b0, result}, {31'b0, m_result});
        check("busy", {31'b0, alu_busy}, {31'b0, m_busy});
        if (rst || m_result) begin
            check("val", result_val, m_val);
            check("rob_pos", {28'b0, result_rob_pos}, {28'b0, m_rob});
            check("jump", {31'b0, result_jump}, {31'b0, m_jump});
            check("pc", result_pc, m_pc);
        end
    end

    task automatic set_op(input bit [6:0] op, input bit [2:0] f3, input bit f1, input bit fm,
                          input bit [31:0] a, input bit [31:0] b, input bit [31:0] imm,
                          input bit [31:0] pc, input bit [3:0] rob);
        alu_opcode = op; alu_func3 = f3; alu_func1 = f1; alu_func_m = fm;
        alu_val1 = a; alu_val2 = b; alu_imm = imm; alu_pc = pc; alu_rob_pos = rob;
    endtask

    task automatic issue(input bit [6:0] op, input bit [2:0] f3, input bit f1, input bit fm,
                         input bit [31:0] a, input bit [31:0] b, input bit [31:0] imm,
                         input bit [31:0] pc, input bit [3:0] rob);
        set_op(op, f3, f1, fm, a, b, imm, pc, rob);
        alu_en = 1'b1;
        @(posedge clk);
        #1;
        alu_en = 1'b0;
    endtask

    function automatic bit [31:0] rv();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit [6:0] ops [7];
        bit [31:0] a;
        ops = '{OP, OPIMM, LUI, AUIPC, JAL, JALR, BRANCH};
        rst = 1'b0; rdy = 1'b1; rollback = 1'b0; alu_en = 1'b0;
        set_op(7'h0, 3'h0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_result", {31'b0, result}, 32'd0);
        check("rst_val", result_val, 32'd0);
        check("rst_pc", result_pc, 32'd0);
        check("rst_rob", {28'b0, result_rob_pos}, 32'd0);
        check("rst_jump", {31'b0, result_jump}, 32'd0);
        check("rst_busy", {31'b0, alu_busy}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        issue(OP, 3'd0, 1'b0, 1'b0, 5, 7, 0, 0, 4'd3);
        @(negedge clk);
        check("add_result", {31'b0, result}, 32'd1);
        check("add_val", result_val, 32'd12);
        check("add_rob", {28'b0, result_rob_pos}, 32'd3);
        check("add_jump", {31'b0, result_jump}, 32'd0);
        check("model_add", m_val, 32'd12);

        issue(OP, 3'd0, 1'b1, 1'b0, 5, 7, 0, 0, 4'd4);
        @(negedge clk);
        check("sub_val", result_val, 32'hFFFF_FFFE);

        issue(BRANCH, 3'd4, 1'b0, 1'b0, 32'hFFFF_FFFF, 1, 32'h20, 32'h100, 4'd5);
        @(negedge clk);
        check("blt_jump", {31'b0, result_jump}, 32'd1);
        check("blt_pc", result_pc, 32'h120);
        check("model_blt_pc", m_pc, 32'h120);

        issue(BRANCH, 3'd6, 1'b0, 1'b0, 32'hFFFF_FFFF, 1, 32'h20, 32'h100, 4'd5);
        @(negedge clk);
        check("bltu_jump", {31'b0, result_jump}, 32'd0);
        check("bltu_pc", result_pc, 32'h104);

        issue(JALR, 3'd0, 1'b0, 1'b0, 32'h1001, 0, 4, 32'h200, 4'd6);
        @(negedge clk);
        check("jalr_val", result_val, 32'h204);
        check("jalr_jump", {31'b0, result_jump}, 32'd1);
        check("jalr_pc", result_pc, 32'h1004);

        issue(OP, 3'd0, 1'b0, 1'b0, 1, 1, 0, 0, 4'd7);
        @(negedge clk);
        check("rb_first", {31'b0, result}, 32'd1);
        set_op(OP, 3'd0, 1'b0, 1'b0, 2, 2, 0, 0, 4'd8);
        alu_en = 1'b1; rollback = 1'b1;
        @(posedge clk); #1;
        alu_en = 1'b0; rollback = 1'b0;
        @(negedge clk);
        check("rb_flush", {31'b0, result}, 32'd0);
        @(negedge clk);
        check("rb_none", {31'b0, result}, 32'd0);

        issue(OP, 3'd0, 1'b0, 1'b0, 9, 1, 0, 0, 4'd9);
        rdy = 1'b0;
        set_op(OPIMM, 3'd0, 1'b0, 1'b0, 100, 0, 1, 0, 4'd1);
        alu_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("rdy_hold", {31'b0, result}, 32'd1);
            check("rdy_hold_val", result_val, 32'd10);
        end
        rdy = 1'b1; alu_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rdy_release", {31'b0, result}, 32'd0);

        issue(OP, 3'd0, 1'b0, 1'b0, 3, 3, 0, 0, 4'd2);
        rst = 1'b1;
        @(negedge clk);
        check("async_rst_result", {31'b0, result}, 32'd0);
        check("async_rst_val", result_val, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

`ifdef ALU_MUL_EN
        issue(OP, 3'd1, 1'b0, 1'b1, 32'h8000_0000, 2, 0, 0, 4'd10);
        set_op(OP, 3'd0, 1'b0, 1'b0, 1, 2, 0, 0, 4'd11);
        alu_en = 1'b1;
        @(negedge clk);
        check("mulh_busy", {31'b0, alu_busy}, 32'd1);
        check("mulh_wait", {31'b0, result}, 32'd0);
        @(posedge clk); #1 alu_en = 1'b0;
        @(negedge clk);
        check("mulh_result", {31'b0, result}, 32'd1);
        check("mulh_val", result_val, 32'hFFFF_FFFF);
        check("mulh_rob", {28'b0, result_rob_pos}, 32'd10);
        check("mulh_idle", {31'b0, alu_busy}, 32'd0);
        @(negedge clk);
        check("mul_en_ignored", {31'b0, result}, 32'd0);

        issue(OP, 3'd0, 1'b0, 1'b1, 3, 5, 0, 0, 4'd12);
        rst = 1'b1;
        @(negedge clk);
        check("mul_rst_busy", {31'b0, alu_busy}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("mul_rst_none", {31'b0, result}, 32'd0);
        @(negedge clk);
        check("mul_rst_none2", {31'b0, result}, 32'd0);
`else
        issue(OP, 3'd0, 1'b0, 1'b1, 3, 4, 0, 0, 4'd12);
        @(negedge clk);
        check("funcm_ignored_val", result_val, 32'd7);
        check("funcm_busy", {31'b0, alu_busy}, 32'd0);
`endif

        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            rdy      = ($urandom_range(0, 9) != 0);
            rollback = ($urandom_range(0, 19) == 0);
            alu_en   = $urandom_range(0, 1) == 1;
            a = rv();
            set_op(($urandom_range(0, 9) > 6) ? 7'($urandom) : ops[$urandom_range(0, 6)],
                   3'($urandom), 1'($urandom), 1'($urandom), a,
                   ($urandom_range(0, 3) == 0) ? a : rv(), rv(), $urandom, 4'($urandom));
            @(posedge clk);
            #1;
        end
        rst = 1'b0; rdy = 1'b1; rollback = 1'b0; alu_en = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
